// File: rtl/ram_burst_master_d1_pkg.sv
// ram_burst_master_d1_pkg: shared state encoding and burst mode constants
package ram_burst_master_d1_pkg;
    typedef enum logic [1:0] {ST_IDLE, ST_WRITE, ST_READ, ST_DONE} state_t;
    localparam logic MODE_READ = 1'b0;
    localparam logic MODE_WRITE = 1'b1;
endpackage

// File: rtl/ram_rd_skid_buf.sv
// ram_rd_skid_buf: 2-entry valid/ready buffer decoupling RAM read latency from the consumer
module ram_rd_skid_buf #(
    parameter int DWIDTH = 32
) (
    input  logic              clock,
    input  logic              reset,
    input  logic [DWIDTH-1:0] in_data,
    input  logic              in_valid,
    output logic [DWIDTH-1:0] out_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [1:0]        count
);
    logic [DWIDTH-1:0] mem [2];
    logic              rd_ptr;
    logic              wr_ptr;
    logic              pop;
    assign out_valid = count != 2'd0;
    assign pop = out_valid && out_ready;
    assign out_data = mem[rd_ptr];
    // push at the write pointer, pop at the read pointer; the producer never pushes when full
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            mem[0] <= '0;
            mem[1] <= '0;
            rd_ptr <= 1'b0;
            wr_ptr <= 1'b0;
            count <= 2'd0;
        end else begin
            if (in_valid) begin
                mem[wr_ptr] <= in_data;
                wr_ptr <= ~wr_ptr;
            end
            if (pop)
                rd_ptr <= ~rd_ptr;
            count <= count + {1'b0, in_valid} - {1'b0, pop};
        end
    end
endmodule

// File: rtl/ram_burst_master_d1.sv
// ram_burst_master_d1: runs one write or read burst between valid/ready streams and a sync-read RAM
module ram_burst_master_d1
    import ram_burst_master_d1_pkg::*;
#(
    parameter int AWIDTH = 3,
    parameter int DWIDTH = 32
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              start,
    input  logic              wr_mode,
    input  logic [AWIDTH-1:0] base_addr,
    input  logic [AWIDTH:0]   len,
    output logic              busy,
    output logic              done,
    output logic [AWIDTH-1:0] ram_addr,
    output logic [DWIDTH-1:0] ram_din,
    output logic              ram_we,
    input  logic [DWIDTH-1:0] ram_dout,
    input  logic [DWIDTH-1:0] s_data,
    input  logic              s_valid,
    output logic              s_ready,
    output logic [DWIDTH-1:0] m_data,
    output logic              m_valid,
    input  logic              m_ready
);
    localparam int DEPTH = 1 << AWIDTH;
    localparam logic [AWIDTH:0] LEN_MAX = (AWIDTH + 1)'(DEPTH);
    localparam logic [AWIDTH:0] LEN_ONE = (AWIDTH + 1)'(1);
    state_t            state;
    state_t            next;
    logic [AWIDTH-1:0] addr;
    logic [AWIDTH:0]   rem;
    logic              inflight;
    logic              wr_hs;
    logic              pop;
    logic              issue;
    logic [1:0]        buf_count;
    assign wr_hs = (state == ST_WRITE) && s_valid;
    assign pop = m_valid && m_ready;
    // a read may issue only if the word it returns is guaranteed a free buffer slot
    assign issue = (state == ST_READ) && (rem != '0) &&
                   (({1'b0, buf_count} + {2'b0, inflight}) < (3'd2 + {2'b0, pop}));
    // state register
    always_ff @(posedge clock or posedge reset) begin
        if (reset)
            state <= ST_IDLE;
        else
            state <= next;
    end
    // next-state: read completes only once nothing is left to issue, in flight or buffered
    always_comb begin
        next = state;
        case (state)
            ST_IDLE:  if (start) next = (len == '0) ? ST_DONE : (wr_mode == MODE_WRITE) ? ST_WRITE : ST_READ;
            ST_WRITE: if (wr_hs && rem == LEN_ONE) next = ST_DONE;
            ST_READ:  if (rem == '0 && !inflight && (buf_count == 2'd0 || (buf_count == 2'd1 && pop))) next = ST_DONE;
            default:  next = ST_IDLE;
        endcase
    end
    // burst address, remaining count and read-in-flight tracking
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            addr <= '0;
            rem <= '0;
            inflight <= 1'b0;
        end else begin
            if (state == ST_IDLE && start) begin
                addr <= base_addr;
                rem <= (len > LEN_MAX) ? LEN_MAX : len;
            end else if (wr_hs || issue) begin
                addr <= addr + 1'b1;
                rem <= rem - LEN_ONE;
            end
            inflight <= issue;
        end
    end
    // outputs decoded from state; write beats are combinational on s_valid
    always_comb begin
        busy = (state == ST_WRITE) || (state == ST_READ);
        done = state == ST_DONE;
        s_ready = state == ST_WRITE;
        ram_we = wr_hs;
        ram_din = wr_hs ? s_data : '0;
        ram_addr = busy ? addr : '0;
    end
    ram_rd_skid_buf #(.DWIDTH(DWIDTH)) u_rd_buf (
        .clock     (clock),
        .reset     (reset),
        .in_data   (ram_dout),
        .in_valid  (inflight),
        .out_data  (m_data),
        .out_valid (m_valid),
        .out_ready (m_ready),
        .count     (buf_count)
    );
endmodule

// File: tb/tb_ram_burst_master_d1.sv
// tb_ram_burst_master_d1: directed bursts against a RAM model and a queue-based expected-traffic model
module tb_ram_burst_master_d1;
    import ram_burst_master_d1_pkg::*;
    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic        start = 1'b0;
    logic        wr_mode = 1'b0;
    logic [2:0]  base_addr = '0;
    logic [3:0]  len = '0;
    logic        busy;
    logic        done;
    logic [2:0]  ram_addr;
    logic [31:0] ram_din;
    logic        ram_we;
    logic [31:0] ram_dout;
    logic [31:0] s_data = '0;
    logic        s_valid = 1'b0;
    logic        s_ready;
    logic [31:0] m_data;
    logic        m_valid;
    logic        m_ready = 1'b0;
    int total = 0;
    int bad = 0;
    logic [31:0] ram [8];
    logic [31:0] model_mem [8];
    logic [2:0]  exp_wa [$];
    logic [31:0] exp_wd [$];
    logic [31:0] exp_rq [$];
    int first_v, done_k, pops, first_pop, last_pop, end_addr;
    logic [31:0] first_word;

    ram_burst_master_d1 dut (
        .clock(clock), .reset(reset), .start(start), .wr_mode(wr_mode),
        .base_addr(base_addr), .len(len), .busy(busy), .done(done),
        .ram_addr(ram_addr), .ram_din(ram_din), .ram_we(ram_we), .ram_dout(ram_dout),
        .s_data(s_data), .s_valid(s_valid), .s_ready(s_ready),
        .m_data(m_data), .m_valid(m_valid), .m_ready(m_ready)
    );

    always #5 clock = ~clock;

    always @(posedge clock) begin
        if (ram_we) ram[ram_addr] <= ram_din;
        ram_dout <= ram[ram_addr];
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", nm, act, exp);
        end
    endtask

    task automatic chk_zero(input string tag);
        chk({tag, "_busy"}, 32'(busy), 0);
        chk({tag, "_done"}, 32'(done), 0);
        chk({tag, "_ram_addr"}, 32'(ram_addr), 0);
        chk({tag, "_ram_din"}, ram_din, 0);
        chk({tag, "_ram_we"}, 32'(ram_we), 0);
        chk({tag, "_s_ready"}, 32'(s_ready), 0);
        chk({tag, "_m_data"}, m_data, 0);
        chk({tag, "_m_valid"}, 32'(m_valid), 0);
    endtask

    // every-cycle compare: writes and read words must match the expected traffic in order
    initial begin
        logic stall;
        logic [31:0] held;
        stall = 1'b0;
        held = '0;
        forever begin
            @(negedge clock);
            if (reset) begin
                stall = 1'b0;
            end else begin
                chk("done_excl_busy", 32'(done & busy), 0);
                if (ram_we) begin
                    chk("we_pending", 32'(exp_wa.size() != 0), 1);
                    if (exp_wa.size() != 0) begin
                        chk("we_addr", 32'(ram_addr), 32'(exp_wa[0]));
                        chk("we_data", ram_din, exp_wd[0]);
                        model_mem[exp_wa[0]] = exp_wd[0];
                        void'(exp_wa.pop_front());
                        void'(exp_wd.pop_front());
                    end
                end
                if (stall) begin
                    chk("stall_valid", 32'(m_valid), 1);
                    chk("stall_data", m_data, held);
                end
                if (m_valid && m_ready) begin
                    chk("rd_pending", 32'(exp_rq.size() != 0), 1);
                    if (exp_rq.size() != 0) begin
                        chk("rd_data", m_data, exp_rq[0]);
                        void'(exp_rq.pop_front());
                    end
                end
                stall = m_valid && !m_ready;
                held = m_data;
            end
        end
    end

    task automatic wr_burst(input int base, input int n, input logic [31:0] d0);
        int bc;
        bc = 0;
        start = 1'b1; wr_mode = MODE_WRITE; base_addr = 3'(base); len = 4'(n);
        for (int i = 0; i < n; i++) begin
            exp_wa.push_back(3'((base + i) % 8));
            exp_wd.push_back(d0 + 32'(i));
        end
        @(posedge clock); #1;
        start = 1'b0;
        for (int i = 0; i < n; i++) begin
            s_valid = 1'b1;
            s_data = d0 + 32'(i);
            bc += int'(busy);
            @(posedge clock); #1;
        end
        s_valid = 1'b0; s_data = '0;
        chk("wr_done", 32'(done), 1);
        chk("wr_busy_cycles", 32'(bc), 32'(n));
        chk("wr_drained", 32'(exp_wa.size()), 0);
        @(posedge clock); #1;
        chk("wr_idle", 32'({done, busy}), 0);
    endtask

    task automatic rd_burst(input int base, input int n, input int pat, input bit busy_start);
        start = 1'b1; wr_mode = MODE_READ; base_addr = 3'(base); len = 4'(n);
        for (int i = 0; i < n; i++) exp_rq.push_back(model_mem[(base + i) % 8]);
        @(posedge clock); #1;
        start = 1'b0;
        first_v = -1; done_k = -1; pops = 0; first_pop = -1; last_pop = -1; end_addr = -1; first_word = '0;
        for (int k = 0; k < 60 && done_k < 0; k++) begin
            m_ready = (pat == 0) ? 1'b1 : (k % 3 == 0);
            if (busy_start && k == 1) begin
                start = 1'b1; wr_mode = MODE_WRITE; base_addr = 3'd5; len = 4'd3;
            end else begin
                start = 1'b0; wr_mode = MODE_READ;
            end
            if (done) begin
                done_k = k;
            end else begin
                if (m_valid && first_v < 0) first_v = k;
                if (m_valid && m_ready) begin
                    if (first_pop < 0) begin first_pop = k; first_word = m_data; end
                    last_pop = k;
                    pops++;
                end
                end_addr = int'(ram_addr);
                @(posedge clock); #1;
            end
        end
        m_ready = 1'b0; start = 1'b0;
        chk("rd_finished", 32'(done_k >= 0), 1);
        chk("rd_pops", 32'(pops), 32'(n));
        chk("rd_drained", 32'(exp_rq.size()), 0);
        if (n > 0) chk("rd_end_addr", 32'(end_addr), 32'((base + n) % 8));
        @(posedge clock); #1;
        chk("rd_idle", 32'({done, busy, m_valid}), 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int p;
        repeat (2) @(posedge clock);
        #1;
        chk_zero("reset");
        reset = 1'b0;
        // fill the whole RAM from address 0
        wr_burst(0, 8, 32'hA0);
        chk("model_pin_a5", model_mem[5], 32'hA5);
        // full readback with m_ready held high: one word per cycle
        rd_burst(0, 8, 0, 1'b0);
        chk("rd8_first_valid", 32'(first_v), 2);
        chk("rd8_done_k", 32'(done_k), 10);
        chk("rd8_consecutive", 32'(last_pop - first_pop), 7);
        chk("rd8_first_word", first_word, 32'hA0);
        chk("rd8_end_addr", 32'(end_addr), 0);
        // wrapping read 6,7,0,1
        rd_burst(6, 4, 0, 1'b0);
        chk("wrap_first_word", first_word, 32'hA6);
        chk("wrap_end_addr", 32'(end_addr), 2);
        chk("wrap_done_k", 32'(done_k), 6);
        // wrapping write then a read straddling old and new data
        wr_burst(6, 4, 32'hB0);
        chk("model_pin_b1", model_mem[1], 32'hB3);
        rd_burst(4, 4, 0, 1'b0);
        chk("mix_first_word", first_word, 32'hA4);
        // backpressure with m_ready pattern 1,0,0
        rd_burst(1, 5, 1, 1'b0);
        chk("bp_first_word", first_word, 32'hB3);
        // zero-length bursts in both modes
        wr_burst(3, 0, 32'hC0);
        rd_burst(2, 0, 0, 1'b0);
        chk("len0_done_k", 32'(done_k), 0);
        chk("len0_no_valid", 32'(first_v), 32'(-1));
        // start pulsed mid-burst must be ignored
        rd_burst(0, 8, 0, 1'b1);
        chk("busy_start_done_k", 32'(done_k), 10);
        // async reset during a read burst
        start = 1'b1; wr_mode = MODE_READ; base_addr = 3'd0; len = 4'd8;
        for (int i = 0; i < 8; i++) exp_rq.push_back(model_mem[i]);
        @(posedge clock); #1;
        start = 1'b0; m_ready = 1'b1; p = 0;
        for (int k = 0; k < 20 && p < 3; k++) begin
            if (m_valid && m_ready) p++;
            @(posedge clock); #1;
        end
        chk("rst_beats", 32'(p), 3);
        reset = 1'b1;
        #1;
        exp_rq.delete();
        m_ready = 1'b0;
        chk_zero("midrst");
        repeat (3) begin
            @(posedge clock); #1;
            chk("midrst_no_done", 32'(done), 0);
        end
        reset = 1'b0;
        @(posedge clock); #1;
        chk("postrst_quiet", 32'({done, busy}), 0);
        rd_burst(0, 8, 0, 1'b0);
        chk("postrst_done_k", 32'(done_k), 10);
        chk("postrst_first_word", first_word, 32'hB2);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/ram_burst_master_d1.md
Name: ram_burst_master_d1

Overview:
- Initiator-side controller for the single-port synchronous-read data RAM (registered read address, 1-cycle read latency, write-enable port).
- On a start pulse it runs one burst of `len` words from `base_addr`, in one of two modes:
  - write burst: drains an input valid/ready stream into the RAM;
  - read burst: streams RAM contents out on a valid/ready stream.
- Sits between datapath stream producers/consumers and the RAM, so stream logic never handles RAM latency.

Parameters:
- AWIDTH, 3, RAM address width; DEPTH = 1 << AWIDTH (localparam).
- DWIDTH, 32, data word width.

Ports:
- clock  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-high reset.
- start  in  1  burst request; sampled only in IDLE.
- wr_mode  in  1  1 = write burst, 0 = read burst; sampled with start.
- base_addr  in  AWIDTH  first RAM address; sampled with start.
- len  in  AWIDTH+1  word count, 0..DEPTH; sampled with start.
- busy  out  1  high from the cycle after start is accepted until done.
- done  out  1  one-cycle pulse at burst completion.
- ram_addr  out  AWIDTH  to RAM addr.
- ram_din  out  DWIDTH  to RAM din.
- ram_we  out  1  to RAM we.
- ram_dout  in  DWIDTH  from RAM dout (valid the cycle after the address is presented).
- s_data  in  DWIDTH  write stream data.
- s_valid  in  1  write stream valid.
- s_ready  out  1  write stream ready.
- m_data  out  DWIDTH  read stream data.
- m_valid  out  1  read stream valid.
- m_ready  in  1  read stream ready.

Behaviour:
- Reset values: all outputs 0 (busy, done, ram_addr, ram_din, ram_we, s_ready, m_data, m_valid). Internal address, remaining count, in-flight flag and output buffer are cleared.
- Reset mid-burst: the burst is abandoned, buffered read data is discarded, and no done pulse is generated.
- States: IDLE, WRITE, READ, DONE.
- IDLE:
  - start=1 latches wr_mode, base_addr and len.
  - len=0 goes directly to DONE.
  - Otherwise go to WRITE or READ.
  - start is ignored outside IDLE.
- WRITE:
  - s_ready=1.
  - On each s_valid&s_ready cycle, ram_we=1, ram_din=s_data, ram_addr=current address (combinational from s_valid). ram_we=0 otherwise.
  - Address increments mod DEPTH (7 wraps to 0 when AWIDTH=3); the remaining count decrements.
  - On the last beat go to DONE. s_ready is 0 in all other states.
- READ, issue side:
  - ram_we=0 always; ram_addr=current address.
  - A read issues in cycle t when remaining>0 and (occupancy + inflight - pop) < 2, where occupancy is the 2-entry output buffer count and pop = m_valid&m_ready.
  - On issue, address increments mod DEPTH, remaining decrements, and inflight is set for cycle t+1.
- READ, capture side:
  - In cycle t+1, ram_dout is written into the output buffer at the clock edge.
  - m_valid rises in cycle t+2: 2 cycles from issue to m_valid.
- READ, throughput and ordering:
  - With m_ready held high, one word per cycle.
  - m_data/m_valid are held stable while m_valid=1 and m_ready=0.
  - The buffer never overflows; words leave in address order.
- READ to DONE: when remaining=0, inflight=0 and the buffer is empty after the final pop.
- DONE: done=1 and busy=0 for one cycle, then IDLE.
- Earliest next burst: start is accepted in the cycle after DONE.
- len=DEPTH: all locations are touched once, and the address returns to base_addr.

Decomposition:
- Shared package:
  - state encoding typedef (IDLE/WRITE/READ/DONE);
  - mode constants MODE_READ=0, MODE_WRITE=1.
- Sub-module ram_rd_skid_buf: 2-entry valid/ready buffer with count output. It is instantiated once for the read path.

Test Plan:
- Write then read back (AWIDTH=3):
  - Write burst, base 0, len 8, s_data 0xA0..0xA7 with s_valid held high -> 8 consecutive ram_we pulses to addr 0..7, done one cycle after the last beat.
  - Then a read burst, base 0, len 8, m_ready=1 -> m_data 0xA0..0xA7 on 8 consecutive cycles, first m_valid 2 cycles after the first issue.
- Wrap: read base 6, len 4 -> ram_addr sequence 6,7,0,1; m_data equals the words stored at 6,7,0,1; final address back to 2.
- Backpressure: read len 5 with m_ready toggling 1,0,0,1,... -> no lost or duplicated words, m_data stable while stalled, at most 2 reads outstanding past pop.
- len=0 and busy start:
  - len=0, either mode -> done one cycle after start, no ram_we, no m_valid.
  - start pulsed during busy -> ignored.
- Async reset during read beat 3 of 8 -> all outputs 0 immediately; no done pulse; the next burst after reset release behaves normally.
